// File: rtl/sar_pkg.sv
// Shared definitions for the SAR conversion path: code width and a
// constant-foldable ceil(log2) helper for sizing pointers and counters.
package sar_pkg;

  localparam int SAR_W = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/sar_result_fifo.sv
// First-word-fall-through result queue with occupancy count.
// The caller must never push while full unless it pops in the same cycle.
module sar_result_fifo
  import sar_pkg::*;
#(
  parameter int W     = SAR_W,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [W-1:0]           head,
  output logic [clog2(DEPTH):0]  level,
  output logic                   full
);

  localparam int AW = clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;

  assign do_pop = pop & (level != '0);
  assign full   = (level == (AW + 1)'(DEPTH));
  // Gate the head so stale storage never shows while the queue is empty.
  assign head   = (level != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sar_avg_fifo.sv
// Averages groups of 2^AVG_LOG2 SAR codes with round-half-up and queues
// the results for a valid/ready consumer; dropped results set a sticky flag.
module sar_avg_fifo
  import sar_pkg::*;
#(
  parameter int AVG_LOG2   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [SAR_W-1:0]            sar_in,
  input  logic                        eoc_in,
  input  logic                        flush,
  output logic [SAR_W-1:0]            out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [clog2(FIFO_DEPTH):0]  level,
  output logic                        overflow,
  input  logic                        clr_ovf
);

  localparam int ACC_W = SAR_W + AVG_LOG2;
  localparam logic [ACC_W-1:0] RND = ACC_W'((1 << AVG_LOG2) >> 1);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [SAR_W-1:0] result;
  logic             last_sample;
  logic             push_req;
  logic             push_ok;
  logic             pop;
  logic             full;
  logic             drop;

  // Full-group sum plus half an LSB never exceeds ACC_W bits.
  assign sum      = acc + ACC_W'(sar_in) + RND;
  assign result   = sum[ACC_W-1:AVG_LOG2];

  assign push_req = eoc_in & ~flush & last_sample;
  assign out_valid = (level != '0);
  assign pop      = out_valid & out_ready & ~flush;
  assign push_ok  = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  generate
    if (AVG_LOG2 == 0) begin : g_no_cnt
      assign last_sample = 1'b1;
    end else begin : g_cnt
      logic [AVG_LOG2-1:0] cnt;
      assign last_sample = &cnt;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                 cnt <= '0;
        else if (flush)          cnt <= '0;
        else if (eoc_in)         cnt <= cnt + 1'b1;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  acc <= '0;
    else if (flush)           acc <= '0;
    else if (eoc_in) begin
      if (last_sample)        acc <= '0;
      else                    acc <= acc + ACC_W'(sar_in);
    end
  end

  // A drop in the same cycle as clr_ovf keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  sar_result_fifo #(
    .W     (SAR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_ok),
    .push_data (result),
    .pop       (pop),
    .flush     (flush),
    .head      (out_data),
    .level     (level),
    .full      (full)
  );

endmodule

// File: tb/tb_sar_avg_fifo.sv
// Directed bench: an averaging instance (AVG_LOG2=2) and a pass-through
// instance (AVG_LOG2=0), both with a 4-entry result FIFO.
module tb_sar_avg_fifo;

  logic clk;
  logic rst;

  logic [7:0] a_sar, a_data;
  logic       a_eoc, a_flush, a_ready, a_clr, a_valid, a_ovf;
  logic [2:0] a_level;

  logic [7:0] p_sar, p_data;
  logic       p_eoc, p_flush, p_ready, p_clr, p_valid, p_ovf;
  logic [2:0] p_level;

  int checks = 0;
  int errors = 0;

  sar_avg_fifo #(.AVG_LOG2(2), .FIFO_DEPTH(4)) u_avg (
    .clk(clk), .rst(rst), .sar_in(a_sar), .eoc_in(a_eoc), .flush(a_flush),
    .out_data(a_data), .out_valid(a_valid), .out_ready(a_ready),
    .level(a_level), .overflow(a_ovf), .clr_ovf(a_clr)
  );

  sar_avg_fifo #(.AVG_LOG2(0), .FIFO_DEPTH(4)) u_pt (
    .clk(clk), .rst(rst), .sar_in(p_sar), .eoc_in(p_eoc), .flush(p_flush),
    .out_data(p_data), .out_valid(p_valid), .out_ready(p_ready),
    .level(p_level), .overflow(p_ovf), .clr_ovf(p_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] sar;
    logic       eoc;
    logic       flush;
    logic       ready;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [2:0] exp_level;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic [7:0] sar, input logic eoc, input logic fl,
                              input logic rdy, input logic ev, input logic [7:0] ed,
                              input logic [2:0] el);
    vec_t v;
    v.sar = sar; v.eoc = eoc; v.flush = fl; v.ready = rdy;
    v.exp_valid = ev; v.exp_data = ed; v.exp_level = el;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic a_drive(input logic [7:0] sar, input logic eoc, input logic fl,
                         input logic rdy, input logic clr);
    a_sar = sar; a_eoc = eoc; a_flush = fl; a_ready = rdy; a_clr = clr;
    @(posedge clk); #1;
    a_eoc = 1'b0; a_flush = 1'b0; a_clr = 1'b0;
  endtask

  task automatic p_drive(input logic [7:0] sar, input logic eoc, input logic rdy);
    p_sar = sar; p_eoc = eoc; p_ready = rdy;
    @(posedge clk); #1;
    p_eoc = 1'b0;
  endtask

  // Four equal codes v; ready/clr only asserted on the completing sample.
  task automatic a_group(input logic [7:0] v, input logic rdy_last, input logic clr_last);
    for (int k = 0; k < 3; k++) a_drive(v, 1'b1, 1'b0, 1'b0, 1'b0);
    a_drive(v, 1'b1, 1'b0, rdy_last, clr_last);
  endtask

  initial begin
    logic [7:0] exp_q [4];

    rst = 1'b1;
    a_sar = '0; a_eoc = 0; a_flush = 0; a_ready = 0; a_clr = 0;
    p_sar = '0; p_eoc = 0; p_flush = 0; p_ready = 0; p_clr = 0;
    #1;
    chk("reset a_valid", a_valid, 0);
    chk("reset a_data",  a_data,  0);
    chk("reset a_level", a_level, 0);
    chk("reset a_ovf",   a_ovf,   0);
    @(posedge clk); #1;
    rst = 1'b0;

    vt.push_back(mk(10,  1, 0, 1, 0, 0,   0));
    vt.push_back(mk(11,  1, 0, 1, 0, 0,   0));
    vt.push_back(mk(11,  1, 0, 1, 0, 0,   0));
    vt.push_back(mk(12,  1, 0, 1, 1, 11,  1));
    vt.push_back(mk(0,   0, 0, 1, 0, 0,   0));
    vt.push_back(mk(255, 1, 0, 1, 0, 0,   0));
    vt.push_back(mk(255, 1, 0, 1, 0, 0,   0));
    vt.push_back(mk(255, 1, 0, 1, 0, 0,   0));
    vt.push_back(mk(255, 1, 0, 1, 1, 255, 1));
    vt.push_back(mk(0,   1, 0, 0, 1, 255, 1));
    vt.push_back(mk(0,   1, 0, 0, 1, 255, 1));
    vt.push_back(mk(0,   1, 0, 0, 1, 255, 1));
    vt.push_back(mk(2,   1, 0, 0, 1, 255, 2));
    vt.push_back(mk(0,   0, 0, 1, 1, 1,   1));
    vt.push_back(mk(0,   0, 0, 1, 0, 0,   0));
    vt.push_back(mk(5,   1, 0, 0, 0, 0,   0));
    vt.push_back(mk(5,   1, 0, 0, 0, 0,   0));
    vt.push_back(mk(7,   1, 1, 0, 0, 0,   0));
    vt.push_back(mk(8,   1, 0, 0, 0, 0,   0));
    vt.push_back(mk(8,   1, 0, 0, 0, 0,   0));
    vt.push_back(mk(8,   1, 0, 0, 0, 0,   0));
    vt.push_back(mk(8,   1, 0, 0, 1, 8,   1));
    vt.push_back(mk(0,   0, 0, 0, 1, 8,   1));
    vt.push_back(mk(0,   0, 0, 1, 0, 0,   0));

    foreach (vt[i]) begin
      a_drive(vt[i].sar, vt[i].eoc, vt[i].flush, vt[i].ready, 1'b0);
      chk($sformatf("vec%0d valid", i), a_valid, vt[i].exp_valid);
      chk($sformatf("vec%0d data",  i), a_data,  vt[i].exp_data);
      chk($sformatf("vec%0d level", i), a_level, vt[i].exp_level);
      chk($sformatf("vec%0d ovf",   i), a_ovf,   0);
    end

    // Full FIFO, push and pop on the same edge.
    for (int g = 1; g <= 4; g++) a_group(8'(g), 1'b0, 1'b0);
    chk("fill level", a_level, 4);
    chk("fill head",  a_data,  1);
    a_group(8'd9, 1'b1, 1'b0);
    chk("full push+pop level", a_level, 4);
    chk("full push+pop ovf",   a_ovf,   0);
    exp_q = '{8'd2, 8'd3, 8'd4, 8'd9};
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d data", k), a_data, exp_q[k]);
      a_drive(0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk($sformatf("drain%0d level", k), a_level, 3 - k);
    end
    chk("drained valid", a_valid, 0);

    // Drop with clr_ovf in the same cycle: set wins, FIFO untouched.
    for (int g = 1; g <= 4; g++) a_group(8'(g), 1'b0, 1'b0);
    a_group(8'd50, 1'b0, 1'b1);
    chk("drop+clr ovf",   a_ovf,   1);
    chk("drop level",     a_level, 4);
    exp_q = '{8'd1, 8'd2, 8'd3, 8'd4};
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("postdrop%0d data", k), a_data, exp_q[k]);
      a_drive(0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    chk("postdrop level", a_level, 0);

    // Flush of a non-empty FIFO leaves overflow alone.
    a_group(8'd5, 1'b0, 1'b0);
    a_group(8'd6, 1'b0, 1'b0);
    chk("preflush level", a_level, 2);
    a_drive(0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("flush level", a_level, 0);
    chk("flush valid", a_valid, 0);
    chk("flush ovf",   a_ovf,   1);
    a_drive(0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr ovf", a_ovf, 0);

    // Pass-through: five codes into a four-entry FIFO with no consumer.
    for (int k = 1; k <= 5; k++) begin
      p_drive(8'(k), 1'b1, 1'b0);
      chk($sformatf("pt push%0d level", k), p_level, (k > 4) ? 4 : k);
      chk($sformatf("pt push%0d ovf", k),   p_ovf,   (k == 5) ? 1 : 0);
      chk($sformatf("pt push%0d head", k),  p_data,  1);
    end
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("pt pop%0d data", k), p_data, k);
      p_drive(0, 1'b0, 1'b1);
    end
    chk("pt empty valid", p_valid, 0);
    p_drive(8'd6, 1'b1, 1'b0);
    p_drive(8'd7, 1'b1, 1'b0);
    chk("pt level2", p_level, 2);
    chk("pt ovf kept", p_ovf, 1);

    // Leave the averager mid-group, then reset asynchronously.
    a_drive(8'd30, 1'b1, 1'b0, 1'b0, 1'b0);
    a_drive(8'd30, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst pt level", p_level, 0);
    chk("arst pt valid", p_valid, 0);
    chk("arst pt data",  p_data,  0);
    chk("arst pt ovf",   p_ovf,   0);
    chk("arst avg level", a_level, 0);
    chk("arst avg valid", a_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    a_drive(8'd20, 1'b1, 1'b0, 1'b0, 1'b0);
    a_drive(8'd20, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("fresh group half", a_valid, 0);
    a_drive(8'd20, 1'b1, 1'b0, 1'b0, 1'b0);
    a_drive(8'd20, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("fresh group valid", a_valid, 1);
    chk("fresh group data",  a_data,  20);
    chk("fresh group level", a_level, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sar_avg_fifo.md
# sar_avg_fifo

Post-processing stage directly downstream of the SAR conversion controller. Captures each completed 8-bit SAR code on its end-of-conversion pulse, averages groups of 2^AVG_LOG2 consecutive codes with round-half-up, and queues the averaged results in a small first-word-fall-through FIFO. A valid/ready handshake delivers them to the readout logic. Overflow is flagged, never silently hidden.

## Interface
- AVG_LOG2, default 2: log2 of samples per average. Legal range 0..4; 0 means pass-through.
- FIFO_DEPTH, default 4: result FIFO entries. Power of two, at least 2.
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset; clears all state.
- sar_in  in  8  conversion code; valid only in the cycle eoc_in=1.
- eoc_in  in  1  one-cycle end-of-conversion pulse from the SAR controller.
- flush  in  1  synchronous clear of the accumulator, sample counter and FIFO.
- out_data  out  8  averaged code at the FIFO head.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data when out_valid & out_ready.
- level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky; set when a result is dropped.
- clr_ovf  in  1  synchronous clear of overflow.

## Operation
- Accumulator acc is 8+AVG_LOG2 bits wide. Sample counter cnt is AVG_LOG2 bits wide; when AVG_LOG2=0 it is absent and every sample is the last.
- On a clock edge with eoc_in=1 and flush=0:
  - If cnt != 2^AVG_LOG2-1: acc <= acc+sar_in and cnt <= cnt+1.
  - Otherwise (last sample): result = (acc+sar_in+2^(AVG_LOG2-1)) >> AVG_LOG2, with the rounding term 0 when AVG_LOG2=0. The result is pushed to the FIFO, and acc and cnt return to 0.
- The result never exceeds 255; no saturation logic is required.
- Pop happens on any edge with out_valid & out_ready.
- Push and pop in the same edge:
  - FIFO not full: both happen and level is unchanged.
  - FIFO full: the pop frees a slot and the push is accepted; level stays FIFO_DEPTH and overflow is not set.
- Push while full without pop: the result is discarded, the FIFO is unchanged, and overflow <= 1.
- Pop while empty is impossible because out_valid=0.
- flush=1 wins over eoc_in, out_ready and push. The in-flight sample is discarded, acc, cnt and level go to 0, and overflow is unaffected.
- clr_ovf=1 clears overflow. If a drop occurs in the same cycle, set wins and overflow stays 1.
- A partial average is never emitted. Samples held in acc when flush or rst occurs are lost.
- eoc_in pulses may arrive on consecutive cycles; each one is a sample.

## Timing
- Reset values: out_data=0, out_valid=0, level=0, overflow=0, acc=0, cnt=0, FIFO pointers=0.
- rst asserted mid-average or mid-handshake takes effect immediately and asynchronously. The first sample after rst deassertion starts a fresh group.
- Latency: the last sample of a group arrives with eoc_in high in cycle t. Then out_valid=1 and out_data=result from cycle t+1, provided the FIFO was empty.
- FWFT: out_data shows the head entry combinationally from the registered storage. It is stable while out_valid=1 and out_ready=0.
- Throughput: one result per 2^AVG_LOG2 eoc pulses, and the consumer may pop one per cycle.
- The pointers wrap modulo FIFO_DEPTH. Full/empty is resolved by level, or equivalently by pointers with one extra bit.

## Structure
- Shared package sar_pkg holds:
  - SAR_W=8, which is the code width also used by the SAR controller;
  - the helper function clog2.
- One sub-module, sar_result_fifo: parameterised width and depth, FWFT, push/pop/flush, level and full outputs, with drop-on-full handled in the parent.
- The parent holds the accumulator, the sample counter, rounding, and overflow/clr_ovf.

## Test plan
- AVG_LOG2=2, codes 10,11,11,12 on four eoc pulses, out_ready=1: out_valid pulses one cycle after the 4th eoc, with out_data=11 (46+2=48, >>2=12? no: 44+2=46>>2=11).
- AVG_LOG2=2, four codes of 255: out_data=255. Four codes 0,0,0,2: out_data=1, since 2+2=4>>2 gives 1 and exercises round-half-up.
- AVG_LOG2=0, out_ready=0, 5 eoc pulses with codes 1..5 and FIFO_DEPTH=4: level=4, overflow=1, and pops return 1,2,3,4.
- FIFO full, eoc completing a group while out_ready=1 in the same cycle: level stays 4, overflow stays 0, and the new result appears last.
- Two samples into a group, flush=1 together with eoc: level=0, and the next 4 samples 8,8,8,8 yield exactly one result of 8.
- Async rst pulse between clock edges with level=2 and overflow=1: all outputs are 0 immediately. clr_ovf together with a drop in the same cycle leaves overflow=1.
